timestamp_gen: RTL and testbench

- Parametrised successor to the fixed divide-by-2 timestamp clock.
- Generates NUM_CH gated timestamp clock outputs from timestamp_int_clk using a runtime-programmable divide ratio.
- Keeps a free-running timestamp counter, a saturating overflow counter and a synchronous restart driven by the pattern generator's sync request.
- Sits between clk_wiz_0 and the chip timestamp pins; it is configured from the FTDI register domain.

---
 rtl/timestamp_gen.sv | 168 ++++++++++++++++
 tb/tb_timestamp_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timestamp_gen.sv
// ============================================================================
// Module   : timestamp_gen
// Purpose  : NUM_CH gated timestamp clocks with a programmable divider,
//            a free-running timestamp counter and a saturating wrap counter.
//            Optional macro TS_GRAY_EN presents ts_count Gray-coded.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timestamp_gen #(
  parameter int NUM_CH    = 4,
  parameter int DIV_W     = 8,
  parameter int TS_W      = 32,
  parameter int OVF_W     = 16,
  parameter int DIV_RESET = 0
) (
  input  logic              timestamp_int_clk,
  input  logic              cpu_resetn,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [NUM_CH-1:0] cfg_ch_en,
  input  logic              cfg_load_tgl,
  input  logic              sync_req,
  output logic [NUM_CH-1:0] ts_clk,
  output logic [TS_W-1:0]   ts_count,
  output logic              ts_overflow,
  output logic [OVF_W-1:0]  ovf_count,
  output logic              sync_done,
  output logic              cfg_busy
);

  localparam logic [DIV_W-1:0] C_DIV_INIT = DIV_W'(DIV_RESET);
  localparam logic [TS_W-1:0]  C_TS_MAX   = {TS_W{1'b1}};
  localparam logic [OVF_W-1:0] C_OVF_MAX  = {OVF_W{1'b1}};

  logic [2:0]        ld_sync_q, sy_sync_q;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              phase_q, phase_d;
  logic [DIV_W-1:0]  div_sh_q, div_sh_d;
  logic [NUM_CH-1:0] en_sh_q, en_sh_d;
  logic [DIV_W-1:0]  pend_div_q, pend_div_d;
  logic [NUM_CH-1:0] pend_en_q, pend_en_d;
  logic              busy_q, busy_d;
  logic [TS_W-1:0]   ts_cnt_q, ts_cnt_d;
  logic              ovf_q, ovf_d;
  logic [OVF_W-1:0]  ovf_cnt_q, ovf_cnt_d;
  logic              sync_done_q, sync_done_d;
  logic [NUM_CH-1:0] ts_clk_q, ts_clk_d;

  logic w_load_evt, w_sync_evt, w_at_term;

  // Toggle handshake: any edge is a load; sync restarts on a rising level only.
  assign w_load_evt = ld_sync_q[1] ^ ld_sync_q[2];
  assign w_sync_evt = sy_sync_q[1] & ~sy_sync_q[2];
  assign w_at_term  = (div_cnt_q == div_sh_q);

  always_comb begin
    div_cnt_d   = div_cnt_q;
    phase_d     = phase_q;
    div_sh_d    = div_sh_q;
    en_sh_d     = en_sh_q;
    pend_div_d  = pend_div_q;
    pend_en_d   = pend_en_q;
    busy_d      = busy_q;
    ts_cnt_d    = ts_cnt_q;
    ovf_d       = 1'b0;
    ovf_cnt_d   = ovf_cnt_q;
    sync_done_d = 1'b0;

    // Shadows only change where the new period starts cleanly from a low phase.
    if (busy_q && (w_sync_evt || (w_at_term && phase_q))) begin
      div_sh_d = pend_div_q;
      en_sh_d  = pend_en_q;
      busy_d   = 1'b0;
    end
    if (w_load_evt) begin
      pend_div_d = cfg_div;
      pend_en_d  = cfg_ch_en;
      busy_d     = 1'b1;
    end

    if (w_sync_evt) begin
      div_cnt_d   = '0;
      phase_d     = 1'b0;
      ts_cnt_d    = '0;
      ovf_cnt_d   = '0;
      sync_done_d = 1'b1;
    end else if (w_at_term) begin
      div_cnt_d = '0;
      phase_d   = ~phase_q;
      if (!phase_q) begin
        ts_cnt_d = ts_cnt_q + TS_W'(1);
        if (ts_cnt_q == C_TS_MAX) begin
          ovf_d = 1'b1;
          if (ovf_cnt_q != C_OVF_MAX) begin
            ovf_cnt_d = ovf_cnt_q + OVF_W'(1);
          end
        end
      end
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    ts_clk_d = {NUM_CH{phase_d}} & en_sh_d;
  end

  always_ff @(posedge timestamp_int_clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      ld_sync_q   <= '0;
      sy_sync_q   <= '0;
      div_cnt_q   <= '0;
      phase_q     <= 1'b0;
      div_sh_q    <= C_DIV_INIT;
      en_sh_q     <= '1;
      pend_div_q  <= C_DIV_INIT;
      pend_en_q   <= '1;
      busy_q      <= 1'b0;
      ts_cnt_q    <= '0;
      ovf_q       <= 1'b0;
      ovf_cnt_q   <= '0;
      sync_done_q <= 1'b0;
      ts_clk_q    <= '0;
    end else begin
      ld_sync_q   <= {ld_sync_q[1:0], cfg_load_tgl};
      sy_sync_q   <= {sy_sync_q[1:0], sync_req};
      div_cnt_q   <= div_cnt_d;
      phase_q     <= phase_d;
      div_sh_q    <= div_sh_d;
      en_sh_q     <= en_sh_d;
      pend_div_q  <= pend_div_d;
      pend_en_q   <= pend_en_d;
      busy_q      <= busy_d;
      ts_cnt_q    <= ts_cnt_d;
      ovf_q       <= ovf_d;
      ovf_cnt_q   <= ovf_cnt_d;
      sync_done_q <= sync_done_d;
      ts_clk_q    <= ts_clk_d;
    end
  end

`ifdef TS_GRAY_EN
  logic [TS_W-1:0] ts_gray_q;
  logic            ovf_dly_q;

  always_ff @(posedge timestamp_int_clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      ts_gray_q <= '0;
      ovf_dly_q <= 1'b0;
    end else begin
      ts_gray_q <= ts_cnt_q ^ (ts_cnt_q >> 1);
      ovf_dly_q <= ovf_q;
    end
  end

  assign ts_count    = ts_gray_q;
  assign ts_overflow = ovf_dly_q;
`else
  assign ts_count    = ts_cnt_q;
  assign ts_overflow = ovf_q;
`endif

  assign ts_clk    = ts_clk_q;
  assign ovf_count = ovf_cnt_q;
  assign sync_done = sync_done_q;
  assign cfg_busy  = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_timestamp_gen.sv
// ============================================================================
// Module   : tb_timestamp_gen
// Purpose  : Directed bench for timestamp_gen (TS_W=4, OVF_W=2) with an
//            event scoreboard for sync_done and ts_overflow pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timestamp_gen;

  logic       clk;
  logic       cpu_resetn;
  logic [7:0] cfg_div;
  logic [3:0] cfg_ch_en;
  logic       cfg_load_tgl;
  logic       sync_req;
  logic [3:0] ts_clk;
  logic [3:0] ts_count;
  logic       ts_overflow;
  logic [1:0] ovf_count;
  logic       sync_done;
  logic       cfg_busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int cyc;
    int cnt;
    int ovf;
    int clkv;
  } exp_t;

  exp_t q_sync[$];
  exp_t q_ovf[$];
  exp_t e_mon;

  timestamp_gen #(
    .NUM_CH(4), .DIV_W(8), .TS_W(4), .OVF_W(2), .DIV_RESET(0)
  ) dut (
    .timestamp_int_clk(clk),
    .cpu_resetn       (cpu_resetn),
    .cfg_div          (cfg_div),
    .cfg_ch_en        (cfg_ch_en),
    .cfg_load_tgl     (cfg_load_tgl),
    .sync_req         (sync_req),
    .ts_clk           (ts_clk),
    .ts_count         (ts_count),
    .ts_overflow      (ts_overflow),
    .ovf_count        (ovf_count),
    .sync_done        (sync_done),
    .cfg_busy         (cfg_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every sync_done / ts_overflow pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (cpu_resetn) begin
      if (sync_done) begin
        if (q_sync.size() == 0) chk("sync_unexpected", 32'(sync_done), 32'd0);
        else begin
          e_mon = q_sync.pop_front();
          chk("sync_cycle", cyc, e_mon.cyc);
          chk("sync_count", 32'(ts_count), e_mon.cnt);
          chk("sync_ovf", 32'(ovf_count), e_mon.ovf);
          chk("sync_clk", 32'(ts_clk), e_mon.clkv);
        end
      end
      if (ts_overflow) begin
        if (q_ovf.size() == 0) chk("ovf_unexpected", 32'(ts_overflow), 32'd0);
        else begin
          e_mon = q_ovf.pop_front();
          chk("ovf_count_at_wrap", 32'(ovf_count), e_mon.ovf);
          chk("ts_count_at_wrap", 32'(ts_count), e_mon.cnt);
        end
      end
    end
  end

  logic [3:0] ld2_clk [11];
  logic       ld2_busy[11];

  initial begin
    ld2_clk  = '{4'h5, 4'h5, 4'h5, 4'h5, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF};
    ld2_busy = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    cpu_resetn   = 1'b0;
    cfg_div      = 8'd0;
    cfg_ch_en    = 4'h0;
    cfg_load_tgl = 1'b0;
    sync_req     = 1'b0;
    step(3);
    chk("rst_ts_clk", 32'(ts_clk), 0);
    chk("rst_ts_count", 32'(ts_count), 0);
    chk("rst_ts_overflow", 32'(ts_overflow), 0);
    chk("rst_ovf_count", 32'(ovf_count), 0);
    chk("rst_sync_done", 32'(sync_done), 0);
    chk("rst_cfg_busy", 32'(cfg_busy), 0);

    // Divide-by-2 on all channels out of reset.
    cpu_resetn = 1'b1;
    step(1);
    chk("div2_first_high", 32'(ts_clk), 32'hF);
    chk("div2_first_count", 32'(ts_count), 1);
    step(1);
    chk("div2_first_low", 32'(ts_clk), 0);
    step(17);
    chk("div2_tenth_high", 32'(ts_clk), 32'hF);
    chk("count_after_10", 32'(ts_count), 10);

    // Five wraps of the 4-bit counter; ovf_count saturates at 3.
    q_ovf.push_back('{0, 0, 1, 0});
    q_ovf.push_back('{0, 0, 2, 0});
    q_ovf.push_back('{0, 0, 3, 0});
    q_ovf.push_back('{0, 0, 3, 0});
    q_ovf.push_back('{0, 0, 3, 0});
    step(140);
    chk("wrap5_pulse", 32'(ts_overflow), 1);
    chk("wrap5_ovf_sat", 32'(ovf_count), 3);
    chk("wrap5_count", 32'(ts_count), 0);
    step(1);
    chk("wrap5_pulse_single", 32'(ts_overflow), 0);

    // Load div=3, en=0101: applied at the next falling boundary.
    cfg_div = 8'd3; cfg_ch_en = 4'h5; cfg_load_tgl = 1'b1;
    step(2);
    chk("ld1_busy_before", 32'(cfg_busy), 0);
    step(1);
    chk("ld1_busy_set", 32'(cfg_busy), 1);
    chk("ld1_old_high", 32'(ts_clk), 32'hF);
    step(1);
    chk("ld1_busy_clear", 32'(cfg_busy), 0);
    chk("ld1_boundary_low", 32'(ts_clk), 0);
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("ld1_first_low", 32'(ts_clk), 0);
    end
    for (int k = 0; k < 8; k++) begin
      step(1);
      chk("ld1_period8", 32'(ts_clk), (k < 4) ? 32'h5 : 32'h0);
    end

    // Second load lands mid-high-phase: high phase completes before apply.
    cfg_div = 8'd1; cfg_ch_en = 4'hF; cfg_load_tgl = 1'b0;
    for (int k = 0; k < 11; k++) begin
      step(1);
      chk("ld2_clk", 32'(ts_clk), 32'(ld2_clk[k]));
      chk("ld2_busy", 32'(cfg_busy), 32'(ld2_busy[k]));
    end

    // Sync request raised during a high phase.
    step(1);
    chk("sync_pre_high", 32'(ts_clk), 32'hF);
    sync_req = 1'b1;
    q_sync.push_back('{cyc + 3, 0, 0, 0});
    step(3);
    chk("sync_clk_low", 32'(ts_clk), 0);
    chk("sync_count_zero", 32'(ts_count), 0);
    chk("sync_done_pulse", 32'(sync_done), 1);
    step(1);
    chk("sync_done_single", 32'(sync_done), 0);
    chk("sync_still_low", 32'(ts_clk), 0);
    step(1);
    chk("sync_first_rise", 32'(ts_clk), 32'hF);
    chk("sync_first_count", 32'(ts_count), 1);
    sync_req = 1'b0;

    // Sync coinciding with a wrap: the wrap is discarded.
    step(57);
    chk("pre_wrap_count", 32'(ts_count), 15);
    sync_req = 1'b1;
    q_sync.push_back('{cyc + 3, 0, 0, 0});
    step(3);
    chk("syncwrap_no_pulse", 32'(ts_overflow), 0);
    chk("syncwrap_ovf", 32'(ovf_count), 0);
    chk("syncwrap_count", 32'(ts_count), 0);
    chk("syncwrap_done", 32'(sync_done), 1);
    sync_req = 1'b0;

    // Reset mid-period with a pending load.
    cfg_div = 8'd5; cfg_ch_en = 4'h3; cfg_load_tgl = 1'b1;
    step(3);
    chk("prerst_busy", 32'(cfg_busy), 1);
    #2;
    cpu_resetn   = 1'b0;
    cfg_load_tgl = 1'b0;
    #1;
    chk("midrst_ts_clk", 32'(ts_clk), 0);
    chk("midrst_count", 32'(ts_count), 0);
    chk("midrst_ovf", 32'(ts_overflow), 0);
    chk("midrst_ovf_count", 32'(ovf_count), 0);
    chk("midrst_sync_done", 32'(sync_done), 0);
    chk("midrst_busy", 32'(cfg_busy), 0);
    step(2);
    cpu_resetn = 1'b1;
    step(1);
    chk("postrst_high", 32'(ts_clk), 32'hF);
    chk("postrst_count1", 32'(ts_count), 1);
    step(1);
    chk("postrst_low", 32'(ts_clk), 0);
    step(1);
    chk("postrst_high2", 32'(ts_clk), 32'hF);
    chk("postrst_count2", 32'(ts_count), 2);
    chk("postrst_busy", 32'(cfg_busy), 0);

    step(2);
    chk("sync_events_seen", q_sync.size(), 0);
    chk("ovf_events_seen", q_ovf.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
